conv_rgb_scheduler: RTL and testbench

- Streams a raster RGB image in and forms 3x3 windows with two line buffers.
- Time-shares one external combinational convolution_3x3 datapath across the R, G and B channels: each valid window is issued three times, in R, G, B order.
- The 16-bit results are returned on a valid/ready output stream tagged with channel and last-of-frame.
- Sits between the pixel source and the result writer; replaces bench-driven window sequencing.

---
 rtl/conv_sched_pkg.sv | 20 ++
 rtl/conv_line_buffer.sv | 29 ++
 rtl/conv_rgb_scheduler.sv | 168 ++++++++++++++++
 tb/tb_conv_rgb_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the RGB 3x3 convolution scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam int N_TAPS    = 9;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer: one write and two reads at the same column per accepted pixel.
module conv_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_row1,
  output logic [WIDTH-1:0] rd_row2
);

  logic [WIDTH-1:0] mem_row1 [DEPTH];
  logic [WIDTH-1:0] mem_row2 [DEPTH];

  // Reads return the pre-write contents, so the incoming pixel never sees itself.
  assign rd_row1 = mem_row1[addr];
  assign rd_row2 = mem_row2[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_row2[addr] <= mem_row1[addr];
      mem_row1[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_rgb_scheduler.sv
// Forms 3x3 RGB windows and issues each through one external convolution datapath as R, G, B.
// Optional CONV_SAT_EN: result treated as signed and clamped to [0, 2^PIX_W-1].
//
// state  | meaning
// IDLE   | waiting for start
// ACCEPT | taking pixels until a full window is formed
// ISSUE  | window of current channel on conv_window, result captured
// HOLD   | result held on output until out_ready
// DONE   | one-cycle done pulse after final result
module conv_rgb_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = 8,
  parameter int RES_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [3*PIX_W-1:0]      pix_rgb,
  output logic [N_TAPS*PIX_W-1:0] conv_window,
  input  logic [RES_W-1:0]        conv_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_data,
  output logic [1:0]              out_chan,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0] chan;
  logic last_win;
  logic pix_fire, win_done;
  logic [3*PIX_W-1:0] lb_row1, lb_row2;
  logic [3*PIX_W-1:0] win [N_TAPS];

`ifdef CONV_SAT_EN
  localparam int SAT_MAX = (1 << PIX_W) - 1;

  function automatic logic [RES_W-1:0] shape_result(input logic [RES_W-1:0] r);
    logic signed [RES_W-1:0] s;
    s = $signed(r);
    if (s < 0) return '0;
    if (s > $signed(RES_W'(SAT_MAX))) return RES_W'(SAT_MAX);
    return r;
  endfunction
`else
  function automatic logic [RES_W-1:0] shape_result(input logic [RES_W-1:0] r);
    return r;
  endfunction
`endif

  assign pix_ready = (state == ST_ACCEPT);
  assign pix_fire  = pix_ready && pix_valid;
  assign win_done  = pix_fire && (row >= RW'(2)) && (col >= CW'(2));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (3*PIX_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk     (clk),
    .we      (pix_fire),
    .addr    (col),
    .wdata   (pix_rgb),
    .rd_row1 (lb_row1),
    .rd_row2 (lb_row2)
  );

  // Window columns shift left; the new column is {row-2, row-1, incoming} at this col.
  always_ff @(posedge clk) begin
    if (pix_fire) begin
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= lb_row2;
      win[5] <= lb_row1;
      win[8] <= pix_rgb;
    end
  end

  always_comb begin
    conv_window = '0;
    if (state == ST_ISSUE) begin
      for (int k = 0; k < N_TAPS; k++) begin
        conv_window[k*PIX_W +: PIX_W] = (chan == CH_R) ? win[k][2*PIX_W +: PIX_W] :
                                        (chan == CH_G) ? win[k][PIX_W +: PIX_W] :
                                                         win[k][0 +: PIX_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_ACCEPT;
      ST_ACCEPT: if (win_done) state_n = ST_ISSUE;
      ST_ISSUE:  state_n = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (chan != CH_B) state_n = ST_ISSUE;
          else if (last_win) state_n = ST_DONE;
          else state_n = ST_ACCEPT;
        end
      end
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      chan      <= CH_R;
      last_win  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= CH_R;
      out_last  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (pix_fire) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (win_done) begin
          chan     <= CH_R;
          last_win <= (row == ROW_MAX) && (col == COL_MAX);
        end
      end
      if (state == ST_ISSUE) begin
        out_valid <= 1'b1;
        out_data  <= shape_result(conv_result);
        out_chan  <= chan;
        out_last  <= (chan == CH_B) && last_win;
      end
      if (state == ST_HOLD && out_ready) begin
        out_valid <= 1'b0;
        if (chan != CH_B) chan <= chan + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_rgb_scheduler.sv
// Bench for conv_rgb_scheduler on a 4x4 frame with a sharpen-kernel datapath model.
module tb_conv_rgb_scheduler;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NRES = 3 * (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, pix_ready;
  logic [23:0] pix_rgb;
  logic [71:0] conv_window;
  logic [15:0] conv_result;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_last, busy, done;

  always #5 clk = ~clk;

  conv_rgb_scheduler #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8),
    .RES_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_rgb     (pix_rgb),
    .conv_window (conv_window),
    .conv_result (conv_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [15:0] sharpen(input logic [71:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += ((k == 4) ? 9 : -1) * int'(w[k*8 +: 8]);
    return 16'(s);
  endfunction

  assign conv_result = sharpen(conv_window);

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  chan;
    logic        last;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] obs[$];
  logic [23:0] img [NPIX];
  int          checks = 0, errors = 0;
  int          cyc = 0, pix_cnt, done_cnt, last_cnt, stall_cycles, pix11_cyc, first_valid_cyc;
  bit          win_cap;
  logic [71:0] cap_win;
  bit          ready_rand, stall_req, abort;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input int i, input logic [15:0] e);
    if (obs.size() > i) chk(name, 72'(obs[i]), 72'(e));
    else begin
      checks++;
      errors++;
      $display("FAIL %s missing result index %0d", name, i);
    end
  endtask

  function automatic logic [15:0] clamp(input int s);
`ifdef CONV_SAT_EN
    if (s < 0) return 16'd0;
    if (s > 255) return 16'd255;
`endif
    return 16'(s);
  endfunction

  // Reference: every interior pixel is a window centre, issued R, G, B in raster order.
  task automatic build_model();
    int s;
    logic [23:0] p;
    res_t e;
    exp_q.delete();
    for (int wr = 2; wr < H; wr++)
      for (int wc = 2; wc < W; wc++)
        for (int ch = 0; ch < 3; ch++) begin
          s = 0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
              p = img[(wr - 2 + dr) * W + (wc - 2 + dc)];
              s += ((dr == 1 && dc == 1) ? 9 : -1) * int'(p[(2 - ch) * 8 +: 8]);
            end
          e.data = clamp(s);
          e.chan = 2'(ch);
          e.last = (wr == H - 1) && (wc == W - 1) && (ch == 2);
          exp_q.push_back(e);
        end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result data=%0h chan=%0d", out_data, out_chan);
          end else begin
            chk("out_data", 72'(out_data), 72'(exp_q[0].data));
            chk("out_chan", 72'(out_chan), 72'(exp_q[0].chan));
            chk("out_last", 72'(out_last), 72'(exp_q[0].last));
            if (out_ready) begin
              obs.push_back(out_data);
              if (out_last) last_cnt++;
              void'(exp_q.pop_front());
            end else stall_cycles++;
          end
          chk("pix_ready_while_result", 72'(pix_ready), 72'(0));
          chk("busy_while_result", 72'(busy), 72'(1));
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (pix_valid && pix_ready) begin
          pix_cnt++;
          if (pix_cnt == 11) pix11_cyc = cyc;
        end
        if (done) done_cnt++;
        if (!win_cap && conv_window != 72'd0) begin
          win_cap = 1'b1;
          cap_win = conv_window;
        end
      end
    end
  endtask

  task automatic ready_driver();
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && out_valid) begin
        stall_req = 1'b0;
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end else begin
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  endtask

  task automatic feed(input bit rnd);
    int idx, guard;
    bit fire;
    idx = 0;
    guard = 0;
    while (idx < NPIX && guard < 4000 && !abort) begin
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_rgb   = img[idx];
      @(negedge clk);
      fire = pix_valid && pix_ready && !rst;
      @(posedge clk);
      #1;
      if (fire) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    if (idx < NPIX && !abort) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", idx, NPIX);
    end
  endtask

  task automatic clear_counters();
    obs.delete();
    pix_cnt = 0;
    done_cnt = 0;
    last_cnt = 0;
    stall_cycles = 0;
    win_cap = 1'b0;
    first_valid_cyc = -1;
    pix11_cyc = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit rnd_valid, input bit midstart);
    int n;
    build_model();
    clear_counters();
    pulse_start();
    fork
      feed(rnd_valid);
      begin
        if (midstart) begin
          repeat (25) @(posedge clk);
          #1;
          chk({tag, "_busy_at_midstart"}, 72'(busy), 72'(1));
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 72'(done_cnt), 72'(1));
    chk({tag, "_pixels"}, 72'(pix_cnt), 72'(NPIX));
    chk({tag, "_results"}, 72'(obs.size()), 72'(NRES));
    chk({tag, "_pending"}, 72'(exp_q.size()), 72'(0));
    chk({tag, "_last_count"}, 72'(last_cnt), 72'(1));
    chk({tag, "_idle_busy"}, 72'(busy), 72'(0));
  endtask

  task automatic run_tests();
    int n;
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_rgb = '0;
    ready_rand = 1'b0;
    stall_req = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", 72'(pix_ready), 72'(0));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_out_data", 72'(out_data), 72'(0));
    chk("rst_out_chan", 72'(out_chan), 72'(0));
    chk("rst_out_last", 72'(out_last), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_conv_window", conv_window, 72'(0));

    for (int i = 0; i < NPIX; i++) img[i] = {8'd10, 8'd20, 8'd30};
    run_frame("uniform", 1'b0, 1'b0);
    chk_obs("uniform_r", 0, 16'd10);
    chk_obs("uniform_g", 1, 16'd20);
    chk_obs("uniform_b", 2, 16'd30);
    chk("uniform_latency", 72'(first_valid_cyc - pix11_cyc), 72'(2));

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W + c] = {8'(4*r + c), 8'($urandom), 8'($urandom)};
    stall_req = 1'b1;
    run_frame("ramp", 1'b0, 1'b0);
    chk("ramp_first_window", cap_win, 72'h0a_09_08_06_05_04_02_01_00);
    chk_obs("ramp_first_r", 0, 16'd5);
    chk("ramp_stall_cycles", 72'(stall_cycles), 72'(5));

    for (int i = 0; i < NPIX; i++) img[i] = (i == 5) ? {8'd0, 8'd255, 8'd0} : {8'd255, 8'd0, 8'd0};
    run_frame("extreme", 1'b0, 1'b0);
`ifdef CONV_SAT_EN
    chk_obs("extreme_neg", 0, 16'd0);
    chk_obs("extreme_pos", 1, 16'd255);
`else
    chk_obs("extreme_neg", 0, 16'hF808);
    chk_obs("extreme_pos", 1, 16'd2295);
`endif

    for (int i = 0; i < NPIX; i++) img[i] = 24'($urandom);
    build_model();
    clear_counters();
    pulse_start();
    fork
      feed(1'b0);
      begin
        n = 0;
        while (!(obs.size() >= 3 && out_valid) && n < 500) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("midrst_reached_hold", 72'(n < 500), 72'(1));
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 72'(busy), 72'(0));
        chk("midrst_out_valid", 72'(out_valid), 72'(0));
        chk("midrst_pix_ready", 72'(pix_ready), 72'(0));
      end
    join
    exp_q.delete();
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 72'(done_cnt), 72'(0));

    for (int i = 0; i < NPIX; i++) img[i] = 24'($urandom);
    run_frame("after_rst", 1'b0, 1'b0);

    ready_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 24'($urandom);
      run_frame("random", 1'b1, 1'b1);
    end
  endtask

  initial begin
    fork
      monitor();
      ready_driver();
    join_none
    run_tests();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
